// File: rtl/fht_but_pipe.sv
// ---------------------------------------------------------------------------
// fht_but_pipe
//   Pipelined radix-2 Hartley butterfly:
//     m  = round(cos*x1 + sin*x2)          (twiddles carry W_BIT-2 fraction bits)
//     y0 = x0 + m,  y1 = x0 - m            (optionally halved per sample)
//   Outputs are rounded half-up, then saturated (SAT=1) or wrapped (SAT=0) to
//   D_BIT bits. Three register stages, one sample per clock when not stalled.
//
// Ports
//   iCLK        in   1      clock, rising edge
//   iRESET      in   1      synchronous reset, active-high
//   iVALID      in   1      input sample valid
//   iSTALL      in   1      freeze every stage (no accept, outputs held)
//   iSCALE      in   1      halve this sample's result
//   iX_0..iX_2  in   D_BIT  butterfly inputs (x1 * cos, x2 * sin)
//   iSIN, iCOS  in   W_BIT  twiddle factors, unity = 2**(W_BIT-2)
//   iCLR_OF     in   1      clear sticky overflow flag
//   oVALID      out  1      oY_0/oY_1/oOF valid
//   oY_0, oY_1  out  D_BIT  x0 + m, x0 - m
//   oOF         out  1      overflow on this output sample
//   oOF_STICKY  out  1      any overflow since the last clear / reset
// ---------------------------------------------------------------------------
module fht_but_pipe #(
    parameter int D_BIT = 18,
    parameter int W_BIT = 16,
    parameter bit SAT   = 1'b1
) (
    input  logic                    iCLK,
    input  logic                    iRESET,
    input  logic                    iVALID,
    input  logic                    iSTALL,
    input  logic                    iSCALE,
    input  logic signed [D_BIT-1:0] iX_0,
    input  logic signed [D_BIT-1:0] iX_1,
    input  logic signed [D_BIT-1:0] iX_2,
    input  logic signed [W_BIT-1:0] iSIN,
    input  logic signed [W_BIT-1:0] iCOS,
    input  logic                    iCLR_OF,
    output logic                    oVALID,
    output logic signed [D_BIT-1:0] oY_0,
    output logic signed [D_BIT-1:0] oY_1,
    output logic                    oOF,
    output logic                    oOF_STICKY
);

    localparam int R_BIT = D_BIT + W_BIT;      // single product
    localparam int P_BIT = D_BIT + W_BIT + 1;  // sum of two products
    localparam int M_BIT = D_BIT + 1;          // rounded twiddled term
    localparam int S_BIT = D_BIT + 2;          // butterfly sum/difference

    // Half an LSB of m, added before the shift to round half up.
    localparam logic [P_BIT-1:0] M_HALF = {{(P_BIT-1){1'b0}}, 1'b1} << (W_BIT - 3);

    // -----------------------------------------------------------------------
    // Stage 1: input registers
    // -----------------------------------------------------------------------
    logic                    s1_valid;
    logic                    s1_scale;
    logic signed [D_BIT-1:0] s1_x0, s1_x1, s1_x2;
    logic signed [W_BIT-1:0] s1_sin, s1_cos;

    // NOTE: sequential state is written with <= so each stage captures the
    // previous stage's value from before the edge, not the one just computed.
    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            s1_valid <= 1'b0;
        end else if (!iSTALL) begin
            s1_valid <= iVALID;
        end
    end

    // NOTE: datapath registers have no reset; the valid bits alone say whether
    // their contents mean anything, so the reset net stays off the data flops.
    always_ff @(posedge iCLK) begin
        if (!iSTALL) begin
            s1_scale <= iSCALE;
            s1_x0    <= iX_0;
            s1_x1    <= iX_1;
            s1_x2    <= iX_2;
            s1_sin   <= iSIN;
            s1_cos   <= iCOS;
        end
    end

    // -----------------------------------------------------------------------
    // Stage 2: full-width p = cos*x1 + sin*x2
    // -----------------------------------------------------------------------
    logic signed [R_BIT-1:0] cos_ext, sin_ext, x1_ext, x2_ext;
    logic signed [R_BIT-1:0] prod_c, prod_s;
    logic signed [P_BIT-1:0] p_next;

    always_comb begin
        // Operands are widened first so the products keep every bit.
        cos_ext = {{D_BIT{s1_cos[W_BIT-1]}}, s1_cos};
        sin_ext = {{D_BIT{s1_sin[W_BIT-1]}}, s1_sin};
        x1_ext  = {{W_BIT{s1_x1[D_BIT-1]}}, s1_x1};
        x2_ext  = {{W_BIT{s1_x2[D_BIT-1]}}, s1_x2};
        prod_c  = cos_ext * x1_ext;
        prod_s  = sin_ext * x2_ext;
        p_next  = {prod_c[R_BIT-1], prod_c} + {prod_s[R_BIT-1], prod_s};
    end

    logic                    s2_valid;
    logic                    s2_scale;
    logic signed [D_BIT-1:0] s2_x0;
    logic signed [P_BIT-1:0] s2_p;

    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            s2_valid <= 1'b0;
        end else if (!iSTALL) begin
            s2_valid <= s1_valid;
        end
    end

    always_ff @(posedge iCLK) begin
        if (!iSTALL) begin
            s2_scale <= s1_scale;
            s2_x0    <= s1_x0;
            s2_p     <= p_next;
        end
    end

    // -----------------------------------------------------------------------
    // Stage 3: round m, butterfly, optional halving, saturate / wrap
    // -----------------------------------------------------------------------

    // (s + 1) >>> 1: halve with round half up.
    function automatic logic signed [S_BIT-1:0] halve(input logic signed [S_BIT-1:0] s);
        logic signed [S_BIT-1:0] t;
        t = s + {{(S_BIT-1){1'b0}}, 1'b1};
        return t >>> 1;
    endfunction

    // Returns {overflow, result}. The value fits in D_BIT bits exactly when
    // all bits from the D_BIT-1 sign position upward agree.
    function automatic logic [D_BIT:0] clip(input logic signed [S_BIT-1:0] s);
        logic             ovf;
        logic [D_BIT-1:0] y;
        ovf = !((&s[S_BIT-1:D_BIT-1]) || !(|s[S_BIT-1:D_BIT-1]));
        if (ovf && SAT) begin
            y = s[S_BIT-1] ? {1'b1, {(D_BIT-1){1'b0}}} : {1'b0, {(D_BIT-1){1'b1}}};
        end else begin
            y = s[D_BIT-1:0];
        end
        return {ovf, y};
    endfunction

    logic [P_BIT-1:0]        p_rnd;
    logic signed [M_BIT-1:0] m;
    logic signed [S_BIT-1:0] x0_ext, m_ext, sum0, sum1, y0_full, y1_full;
    logic [D_BIT:0]          res0, res1;
    logic                    of_next;

    // NOTE: every signal here is assigned on every path through the block,
    // so the optional halving becomes a mux rather than an inferred latch.
    always_comb begin
        p_rnd   = s2_p + M_HALF;
        m       = M_BIT'(p_rnd >> (W_BIT - 2));
        x0_ext  = {{2{s2_x0[D_BIT-1]}}, s2_x0};
        m_ext   = {m[M_BIT-1], m};
        sum0    = x0_ext + m_ext;
        sum1    = x0_ext - m_ext;
        y0_full = sum0;
        y1_full = sum1;
        if (s2_scale) begin
            y0_full = halve(sum0);
            y1_full = halve(sum1);
        end
        res0    = clip(y0_full);
        res1    = clip(y1_full);
        of_next = res0[D_BIT] | res1[D_BIT];
    end

    // Output registers: bubbles leave oY/oOF at the last valid sample.
    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            oVALID <= 1'b0;
            oY_0   <= '0;
            oY_1   <= '0;
            oOF    <= 1'b0;
        end else if (!iSTALL) begin
            oVALID <= s2_valid;
            if (s2_valid) begin
                oY_0 <= res0[D_BIT-1:0];
                oY_1 <= res1[D_BIT-1:0];
                oOF  <= of_next;
            end
        end
    end

    // Sticky overflow: a new overflowing output beats a simultaneous clear;
    // the clear itself works regardless of stall.
    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            oOF_STICKY <= 1'b0;
        end else if (!iSTALL && s2_valid && of_next) begin
            oOF_STICKY <= 1'b1;
        end else if (iCLR_OF) begin
            oOF_STICKY <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fht_but_pipe.sv
// ---------------------------------------------------------------------------
// tb_fht_but_pipe
//   Directed stimulus for fht_but_pipe (D_BIT=18, W_BIT=16, SAT=1). A
//   transaction-level model tags every accepted sample with the number of
//   unstalled clock edges seen so far; the sample must appear two unstalled
//   edges later. A single compare process checks the DUT against the model on
//   every cycle, and the directed tests add hand-computed literal checks.
// ---------------------------------------------------------------------------
module tb_fht_but_pipe;

    localparam int D_BIT = 18;
    localparam int W_BIT = 16;
    localparam longint Y_MAX = (longint'(1) <<< (D_BIT - 1)) - 1;
    localparam longint Y_MIN = -(longint'(1) <<< (D_BIT - 1));

    logic clk = 1'b0;
    logic rst, valid, stall, scale, clr;
    logic signed [D_BIT-1:0] x0, x1, x2;
    logic signed [W_BIT-1:0] sn, cs;
    logic ovalid, of, ofs;
    logic signed [D_BIT-1:0] y0, y1;

    always #5 clk = ~clk;

    fht_but_pipe #(.D_BIT(D_BIT), .W_BIT(W_BIT), .SAT(1'b1)) dut (
        .iCLK      (clk),
        .iRESET    (rst),
        .iVALID    (valid),
        .iSTALL    (stall),
        .iSCALE    (scale),
        .iX_0      (x0),
        .iX_1      (x1),
        .iX_2      (x2),
        .iSIN      (sn),
        .iCOS      (cs),
        .iCLR_OF   (clr),
        .oVALID    (ovalid),
        .oY_0      (y0),
        .oY_1      (y1),
        .oOF       (of),
        .oOF_STICKY(ofs)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic longint wrap(input longint v, input int n);
        longint r;
        r = v & ((longint'(1) <<< n) - 1);
        if (r >= (longint'(1) <<< (n - 1))) r -= (longint'(1) <<< n);
        return r;
    endfunction

    function automatic void model(input longint a0, a1, a2, c, s, input bit sc,
                                  output longint r0, r1, output bit rof);
        longint p, m;
        longint v[2];
        p    = c * a1 + s * a2;
        m    = wrap((p + (longint'(1) <<< (W_BIT - 3))) >>> (W_BIT - 2), D_BIT + 1);
        v[0] = a0 + m;
        v[1] = a0 - m;
        rof  = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (sc) v[k] = (v[k] + 1) >>> 1;
            if (v[k] > Y_MAX) begin
                rof = 1'b1;
                v[k] = Y_MAX;
            end else if (v[k] < Y_MIN) begin
                rof = 1'b1;
                v[k] = Y_MIN;
            end
        end
        r0 = v[0];
        r1 = v[1];
    endfunction

    typedef struct {
        longint y0;
        longint y1;
        bit     of;
        longint tag;
    } res_t;

    res_t   q[$];
    longint adv = 0;
    bit     exp_valid = 1'b0;
    longint exp_y0 = 0, exp_y1 = 0;
    bit     exp_of = 1'b0, exp_sticky = 1'b0;
    bit     checking = 1'b0;

    always @(posedge clk) begin : mdl
        res_t r;
        bit   popped;
        popped = 1'b0;
        if (rst) begin
            q.delete();
            exp_valid  = 1'b0;
            exp_y0     = 0;
            exp_y1     = 0;
            exp_of     = 1'b0;
            exp_sticky = 1'b0;
        end else begin
            if (!stall) begin
                adv++;
                if (valid) begin
                    model(x0, x1, x2, cs, sn, scale, r.y0, r.y1, r.of);
                    r.tag = adv;
                    q.push_back(r);
                end
                exp_valid = 1'b0;
                if (q.size() > 0 && q[0].tag == adv - 2) begin
                    r = q.pop_front();
                    exp_valid = 1'b1;
                    exp_y0    = r.y0;
                    exp_y1    = r.y1;
                    exp_of    = r.of;
                    popped    = 1'b1;
                end
            end
            if (popped && exp_of) exp_sticky = 1'b1;
            else if (clr)         exp_sticky = 1'b0;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (checking) begin
            check("ovalid", ovalid, exp_valid);
            check("y0", y0, exp_y0);
            check("y1", y1, exp_y1);
            if (exp_valid) check("of", of, exp_of);
            check("of_sticky", ofs, exp_sticky);
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input longint a0, a1, a2, c, s, input bit sc);
        x0    = D_BIT'(a0);
        x1    = D_BIT'(a1);
        x2    = D_BIT'(a2);
        cs    = W_BIT'(c);
        sn    = W_BIT'(s);
        scale = sc;
        valid = 1'b1;
    endtask

    // One sample, then check it is absent after edge n+1 and present after n+2.
    task automatic directed(input string nm, input longint a0, a1, a2, c, s,
                            input bit sc, input longint e0, e1, input bit eof);
        drive(a0, a1, a2, c, s, sc);
        @(negedge clk);
        valid = 1'b0;
        @(negedge clk);
        check({nm, "_early_valid"}, ovalid, 0);
        @(negedge clk);
        check({nm, "_valid"}, ovalid, 1);
        check({nm, "_y0"}, y0, e0);
        check({nm, "_y1"}, y1, e1);
        check({nm, "_of"}, of, eof);
    endtask

    // Stream vectors: x0, x1, x2, cos, sin, scale
    longint v_x0[8]  = '{100, 100, -50, 7, -131072, 0, 5, 0};
    longint v_x1[8]  = '{3, -3, 0, 1000, 131071, -131072, 1, -1};
    longint v_x2[8]  = '{0, 0, 400, 1000, 0, 0, 0, 0};
    longint v_cs[8]  = '{8192, 8192, 0, -11585, 16384, -16384, 8192, 8192};
    longint v_sn[8]  = '{0, 0, 16384, 11585, 0, 0, 0, 0};
    bit     v_sc[8]  = '{0, 0, 1, 1, 0, 1, 0, 0};

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        longint m0, m1;
        bit     mof;
        int     idx;
        int     cyc;

        rst = 1'b1; valid = 1'b0; stall = 1'b0; scale = 1'b0; clr = 1'b0;
        x0 = '0; x1 = '0; x2 = '0; sn = '0; cs = '0;
        repeat (2) @(negedge clk);
        check("rst_ovalid", ovalid, 0);
        check("rst_y0", y0, 0);
        check("rst_y1", y1, 0);
        check("rst_sticky", ofs, 0);
        rst = 1'b0;
        checking = 1'b1;

        // Pin the model with hand-derived values.
        model(1000, 2000, 0, 16384, 0, 1, m0, m1, mof);
        check("model_t1_y0", m0, 1500);
        check("model_t1_y1", m1, -500);
        model(0, 1000, 1000, 11585, 11585, 1, m0, m1, mof);
        check("model_t3_y0", m0, 707);
        check("model_t3_y1", m1, -707);
        model(131071, 131071, 0, 16384, 0, 0, m0, m1, mof);
        check("model_t4_y0", m0, 131071);
        check("model_t4_of", mof, 1);
        model(-50, 0, 400, 0, 16384, 1, m0, m1, mof);
        check("model_half_y0", m0, 175);
        check("model_half_y1", m1, -225);
        model(0, -1, 0, 8192, 0, 0, m0, m1, mof);
        check("model_rnd_neg", m0, 0);
        model(5, 1, 0, 8192, 0, 0, m0, m1, mof);
        check("model_rnd_pos", m0, 6);

        // 1-3: basic arithmetic, scaling, twiddle rounding
        directed("t1", 1000, 2000, 0, 16384, 0, 1, 1500, -500, 0);
        directed("t2", 1000, 2000, 0, 16384, 0, 0, 3000, -1000, 0);
        directed("t3", 0, 1000, 1000, 11585, 11585, 1, 707, -707, 0);

        // 4: saturation and sticky flag
        directed("t4", 131071, 131071, 0, 16384, 0, 0, 131071, 0, 1);
        check("t4_sticky", ofs, 1);
        drive(131071, 131071, 0, 16384, 0, 0);
        @(negedge clk);
        valid = 1'b0;
        @(negedge clk);
        clr = 1'b1;                 // clear coincides with the overflowing output
        @(negedge clk);
        clr = 1'b0;
        check("t4_set_wins", ofs, 1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("t4_clear", ofs, 0);

        // 5: eight back-to-back samples with a two-cycle stall mid-stream
        idx = 0;
        cyc = 0;
        while (idx < 8) begin
            stall = (cyc == 4 || cyc == 5);
            drive(v_x0[idx], v_x1[idx], v_x2[idx], v_cs[idx], v_sn[idx], v_sc[idx]);
            @(negedge clk);
            if (!stall) idx++;
            cyc++;
        end
        stall = 1'b0;
        valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("t5_last_y0", y0, 0);
        check("t5_last_y1", y1, 0);
        check("t5_sticky", ofs, 1);
        repeat (2) @(negedge clk);

        // 6: reset with two samples in flight
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        drive(1000, 2000, 0, 16384, 0, 0);
        @(negedge clk);
        drive(-300, 100, 0, 16384, 0, 0);
        @(negedge clk);
        valid = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_ovalid", ovalid, 0);
        check("t6_y0", y0, 0);
        check("t6_y1", y1, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t6_no_ghost", ovalid, 0);
        end
        directed("t6_new", -300, 100, 0, 16384, 0, 0, -200, -400, 0);
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
